// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: op codes, FSM states, captured control word.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] op;
  } ctl_t;

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle of the serial ALU; master issues start+operands, slave returns status.
interface alu_serial_if #(
  parameter int W = 32
);
  logic         start;
  logic         Ainvert;
  logic         Binvert;
  logic [1:0]   Op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, Ainvert, Binvert, Op, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, Ainvert, Binvert, Op, a, b,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice (ripple carry); Less drives bit 0 of the SLT result.
// msb_cin is the carry into the slice MSB, used for signed overflow on the final slice.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic             Ainvert,
  input  logic             Binvert,
  input  logic             CarryIn,
  input  logic [1:0]       Op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             Less,
  output logic [SLICE-1:0] Result,
  output logic             CarryOut,
  output logic             msb_cin
);
  logic [SLICE-1:0] aa, bb, sum;
  logic [SLICE:0]   c;

  always_comb begin
    aa   = Ainvert ? ~a : a;
    bb   = Binvert ? ~b : b;
    c    = '0;
    c[0] = CarryIn;
    sum  = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = aa[i] ^ bb[i] ^ c[i];
      c[i+1]   = (aa[i] & bb[i]) | (c[i] & (aa[i] ^ bb[i]));
    end
    Result = '0;
    case (Op)
      OP_AND:  Result = aa & bb;
      OP_OR:   Result = aa | bb;
      OP_ADD:  Result = sum;
      default: Result[0] = Less;
    endcase
  end

  assign CarryOut = c[SLICE];
  assign msb_cin  = c[SLICE-1];
endmodule

// File: rtl/alu_serial.sv
// Multi-cycle W-bit ALU stepping one SLICE-bit slice per clock LSB-first; done pulses N+1 clocks after accept.
// No backpressure: start is taken only in IDLE, start while busy is dropped without queuing.
module alu_serial
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int SLICE = 8
) (
  input logic         clk,
  input logic         reset_n,
  alu_serial_if.slave bus
);
  localparam int N  = W / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((SLICE < 1) || (W % SLICE != 0) || (N < 1)) begin : g_param_check
    $error("alu_serial: W must be a non-zero multiple of SLICE");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctl_t          ctl_q, ctl_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  shadow_q, shadow_d, result_q, result_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic          cin_msb_q, cin_msb_d, cout_msb_q, cout_msb_d, sum_msb_q, sum_msb_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_res;
  logic             sl_cout, sl_msb_cin, last, ovf_raw, set;

  assign sl_a    = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign sl_b    = b_q[int'(cnt_q)*SLICE +: SLICE];
  assign last    = (cnt_q == CW'(N - 1));
  assign ovf_raw = cin_msb_q ^ cout_msb_q;
  assign set     = sum_msb_q ^ ovf_raw;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .Ainvert  (ctl_q.ainv),
    .Binvert  (ctl_q.binv),
    .CarryIn  (carry_q),
    .Op       (ctl_q.op),
    .a        (sl_a),
    .b        (sl_b),
    .Less     (1'b0),
    .Result   (sl_res),
    .CarryOut (sl_cout),
    .msb_cin  (sl_msb_cin)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctl_d      = ctl_q;
    a_d        = a_q;
    b_d        = b_q;
    shadow_d   = shadow_q;
    result_d   = result_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    sum_msb_d  = sum_msb_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          ctl_d   = '{ainv: bus.Ainvert, binv: bus.Binvert, op: bus.Op};
          carry_d = bus.Binvert;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        shadow_d[int'(cnt_q)*SLICE +: SLICE] = sl_res;
        carry_d = sl_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // sum MSB is rebuilt here because the slice shows Less, not the sum, for SLT
          cin_msb_d  = sl_msb_cin;
          cout_msb_d = sl_cout;
          sum_msb_d  = a_q[W-1] ^ ctl_q.ainv ^ b_q[W-1] ^ ctl_q.binv ^ sl_msb_cin;
          cnt_d      = '0;
          state_d    = FIX;
        end
      end
      FIX: begin
        if (ctl_q.op == OP_SLT) begin
          result_d    = '0;
          result_d[0] = set;
        end else begin
          result_d = shadow_q;
        end
        ovf_d   = ctl_q.op[1] ? ovf_raw : 1'b0;
        cout_d  = cout_msb_q;
        zero_d  = (result_d == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctl_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shadow_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      sum_msb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_q      <= ctl_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shadow_q   <= shadow_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      sum_msb_q  <= sum_msb_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (SLICE=8, 32, 1) against a whole-word arithmetic reference.
module tb_alu_serial;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start_s;
  logic        ai_s, bi_s;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_serial_if #(.W(32)) if8 ();
  alu_serial_if #(.W(32)) if32 ();
  alu_serial_if #(.W(32)) if1 ();

  assign if8.start  = start_s[0];
  assign if32.start = start_s[1];
  assign if1.start  = start_s[2];
  assign {if8.Ainvert, if8.Binvert, if8.Op, if8.a, if8.b}     = {ai_s, bi_s, op_s, a_s, b_s};
  assign {if32.Ainvert, if32.Binvert, if32.Op, if32.a, if32.b} = {ai_s, bi_s, op_s, a_s, b_s};
  assign {if1.Ainvert, if1.Binvert, if1.Op, if1.a, if1.b}     = {ai_s, bi_s, op_s, a_s, b_s};

  alu_serial #(.W(32), .SLICE(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));
  alu_serial #(.W(32), .SLICE(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  alu_serial #(.W(32), .SLICE(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(if1));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        co;
    logic        ov;
    logic        z;
  } obs_t;

  typedef struct packed {
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic        ai;
    logic        bi;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } dir_t;

  string nm[3]      = '{"s8", "s32", "s1"};
  int    lat_exp[3] = '{5, 2, 33};

  function automatic obs_t peek(input int k);
    obs_t o;
    case (k)
      0:       o = '{busy: if8.busy, done: if8.done, result: if8.result,
                     co: if8.carry_out, ov: if8.overflow, z: if8.zero};
      1:       o = '{busy: if32.busy, done: if32.done, result: if32.result,
                     co: if32.carry_out, ov: if32.overflow, z: if32.zero};
      default: o = '{busy: if1.busy, done: if1.done, result: if1.result,
                     co: if1.carry_out, ov: if1.overflow, z: if1.zero};
    endcase
    return o;
  endfunction

  // Reference: whole-word add with a 33-bit sum, signed overflow from operand/sum signs.
  function automatic exp_t model(input logic [1:0] op, input logic ai, input logic bi,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] aa, bb;
    logic [32:0] s;
    logic        ovr;
    aa  = ai ? ~a : a;
    bb  = bi ? ~b : b;
    s   = {1'b0, aa} + {1'b0, bb} + {32'd0, bi};
    ovr = (aa[31] == bb[31]) && (s[31] != aa[31]);
    case (op)
      2'b00:   e.r = aa & bb;
      2'b01:   e.r = aa | bb;
      2'b10:   e.r = s[31:0];
      default: e.r = {31'd0, s[31] ^ ovr};
    endcase
    e.co = s[32];
    e.ov = op[1] ? ovr : 1'b0;
    e.z  = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Launch one op on all three instances, optionally holding start (with junk operands) for `hold` more edges.
  task automatic run_op(input string tag, input logic [1:0] op, input logic ai, input logic bi,
                        input logic [31:0] av, input logic [31:0] bv, input exp_t e, input int hold);
    int   lat[3];
    int   nd[3];
    obs_t got[3];
    obs_t o;
    @(negedge clk);
    op_s = op; ai_s = ai; bi_s = bi; a_s = av; b_s = bv;
    start_s = 3'b111;
    @(posedge clk); #1;
    if (hold > 0) begin
      a_s = ~av; b_s = bv ^ 32'h5A5A5A5A; op_s = ~op; ai_s = ~ai; bi_s = ~bi;
    end else begin
      start_s = 3'b000;
    end
    for (int k = 0; k < 3; k++) begin
      lat[k] = -1; nd[k] = 0; got[k] = '0;
    end
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == hold) start_s = 3'b000;
      for (int k = 0; k < 3; k++) begin
        o = peek(k);
        if (o.done) begin
          nd[k]++;
          if (lat[k] < 0) begin
            lat[k] = c;
            got[k] = o;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_%s_latency", tag, nm[k]), 64'(lat[k]), 64'(lat_exp[k]));
      chk($sformatf("%s_%s_pulses", tag, nm[k]), 64'(nd[k]), 64'd1);
      chk($sformatf("%s_%s_result", tag, nm[k]), {32'd0, got[k].result}, {32'd0, e.r});
      chk($sformatf("%s_%s_carry", tag, nm[k]), {63'd0, got[k].co}, {63'd0, e.co});
      chk($sformatf("%s_%s_ovf", tag, nm[k]), {63'd0, got[k].ov}, {63'd0, e.ov});
      chk($sformatf("%s_%s_zero", tag, nm[k]), {63'd0, got[k].z}, {63'd0, e.z});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_t        dir[8];
    obs_t        o;
    exp_t        e1, e2;
    int          lat, nd;
    logic [1:0]  op;
    logic        ai, bi;
    logic [31:0] av, bv;
    logic [31:0] corners[4];

    corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    dir[0] = '{OP_ADD, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1,          '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    dir[1] = '{OP_ADD, 1'b0, 1'b1, 32'h5,         32'h5,          '{32'h0,         1'b1, 1'b0, 1'b1}};
    dir[2] = '{OP_ADD, 1'b0, 1'b1, 32'h0,         32'h1,          '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
    dir[3] = '{OP_SLT, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h2,          '{32'h1,         1'b1, 1'b0, 1'b0}};
    dir[4] = '{OP_SLT, 1'b0, 1'b1, 32'h2,         32'hFFFF_FFFD,  '{32'h0,         1'b0, 1'b0, 1'b1}};
    dir[5] = '{OP_SLT, 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF,  '{32'h1,         1'b1, 1'b1, 1'b0}};
    dir[6] = '{OP_AND, 1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F00,  '{32'h0000_000F, 1'b1, 1'b0, 1'b0}};
    dir[7] = '{OP_OR,  1'b0, 1'b0, 32'hF000_0000, 32'h0000_000F,  '{32'hF000_000F, 1'b0, 1'b0, 1'b0}};

    reset_n = 1'b0;
    start_s = 3'b000;
    ai_s = 1'b0; bi_s = 1'b0; op_s = 2'b00; a_s = '0; b_s = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = peek(k);
      chk($sformatf("reset_%s_outputs", nm[k]), {28'd0, o}, 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      o = peek(k);
      chk($sformatf("idle_%s_outputs", nm[k]), {28'd0, o}, 64'd0);
    end

    for (int i = 0; i < 8; i++)
      run_op($sformatf("dir%0d", i), dir[i].op, dir[i].ai, dir[i].bi, dir[i].a, dir[i].b, dir[i].e, 0);

    // start held through RUN with different operands: only the first op counts
    run_op("hold", OP_ADD, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111,
           model(OP_ADD, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111), 2);

    // start in the done cycle is accepted immediately (SLICE=8 instance only)
    e1 = model(OP_ADD, 1'b0, 1'b0, 32'd3, 32'd4);
    e2 = model(OP_AND, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    @(negedge clk);
    op_s = OP_ADD; ai_s = 1'b0; bi_s = 1'b0; a_s = 32'd3; b_s = 32'd4;
    start_s = 3'b001;
    @(posedge clk); #1;
    start_s = 3'b000;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        lat = c;
        break;
      end
    end
    chk("b2b_first_latency", 64'(lat), 64'd5);
    chk("b2b_first_result", {32'd0, if8.result}, {32'd0, e1.r});
    op_s = OP_AND; a_s = 32'hFF00_FF00; b_s = 32'h0FF0_0FF0;
    start_s = 3'b001;
    @(posedge clk); #1;
    start_s = 3'b000;
    chk("b2b_done_drop", {63'd0, if8.done}, 64'd0);
    chk("b2b_busy", {63'd0, if8.busy}, 64'd1);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        lat = c;
        break;
      end
    end
    chk("b2b_second_latency", 64'(lat), 64'd5);
    chk("b2b_second_result", {32'd0, if8.result}, {32'd0, e2.r});
    chk("b2b_second_carry", {63'd0, if8.carry_out}, {63'd0, e2.co});

    // reset in the second RUN cycle aborts without a done pulse
    @(negedge clk);
    op_s = OP_ADD; a_s = 32'd1; b_s = 32'd1;
    start_s = 3'b001;
    @(posedge clk); #1;
    start_s = 3'b000;
    @(posedge clk); #1;
    chk("abort_busy_before", {63'd0, if8.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, if8.busy}, 64'd0);
    chk("abort_result", {32'd0, if8.result}, 64'd0);
    chk("abort_done", {63'd0, if8.done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (if8.done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    chk("abort_idle_busy", {63'd0, if8.busy}, 64'd0);

    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      ai = op[1] ? 1'b0 : 1'($urandom_range(0, 1));
      bi = 1'($urandom_range(0, 1));
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 7) == 0) av = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) bv = corners[$urandom_range(0, 3)];
      run_op($sformatf("rnd%0d", n), op, ai, bi, av, bv, model(op, ai, bi, av, bv), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
